// File: rtl/mem_access_pkg.sv
// Shared types, lane constants and lane-alignment helpers for the load/store unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_MERGE  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Byte lane offsets within a little-endian word
  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  // Pick the addressed byte/half out of a RAM word and sign/zero extend it
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input size_e       size,
                                              input logic        uns);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: res = uns ? {24'd0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: res = uns ? {16'd0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of a RAM word with store data
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  offset,
                                              input size_e       size);
    logic [31:0] res;
    case (size)
      SZ_BYTE: begin
        case (offset)
          LANE0:   res = {word[31:8], data[7:0]};
          LANE1:   res = {word[31:16], data[7:0], word[7:0]};
          LANE2:   res = {word[31:24], data[7:0], word[15:0]};
          LANE3:   res = {data[7:0], word[23:0]};
          default: res = word;
        endcase
      end
      SZ_HALF: res = offset[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
      SZ_WORD: res = data;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment: load extraction/extension and store merge.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  assign load_data  = load_extend(word, offset, size, uns);
  assign merge_data = store_merge(word, data, offset, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: one request at a time, read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic        ram_enab,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [29:0] RAM_WORDS_W = 30'(RAM_WORDS);

  state_e      state_r;
  state_e      state_s;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  size_e       size_r;
  logic        we_r;
  logic        uns_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic        accept_s;
  logic        req_err_s;
  logic [31:0] load_s;
  logic [31:0] merge_s;

  assign accept_s = req_valid && (state_r == ST_IDLE);

  // Request is rejected before touching RAM if misaligned, reserved size or out of range
  assign req_err_s = (req_size == SZ_RSVD)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_addr[31:2] >= RAM_WORDS_W);

  mem_lane_align u_align (
    .word       (ram_rdata),
    .data       (wdata_r),
    .offset     (addr_r[1:0]),
    .size       (size_r),
    .uns        (uns_r),
    .load_data  (load_s),
    .merge_data (merge_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and state-decoded handshake / RAM strobe
  always_comb begin
    state_s    = state_r;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_enab   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept_s) begin
          if (req_err_s) begin
            state_s = ST_RESP;
          end else if (!req_we) begin
            state_s = ST_ACCESS;
          end else if (req_size == SZ_WORD) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_MERGE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_s = ST_RESP;
      ST_MERGE:  state_s = ST_WRITE;
      ST_WRITE: begin
        ram_enab = 1'b1;
        state_s  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_s    = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Request latches, merged write word and held response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      size_r       <= SZ_BYTE;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r       <= req_addr;
            wdata_r      <= req_wdata;
            size_r       <= size_e'(req_size);
            we_r         <= req_we;
            uns_r        <= req_unsigned;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= req_err_s;
          end
        end
        ST_ACCESS: resp_rdata_r <= load_s;
        ST_MERGE:  wdata_r      <= merge_s;
        default: begin
        end
      endcase
    end
  end

  assign ram_addr   = {addr_r[31:2], 2'b00};
  assign ram_wdata  = wdata_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed vector table, reset/back-to-back sequences, random vs model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic        ram_enab;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] ram_mem [0:63];
  logic [31:0] gold    [0:63];
  logic        mem_init;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.RAM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_addr(ram_addr),
    .ram_enab(ram_enab), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h8765_4321;
    return 32'h0101_0101 * i;
  endfunction

  // Behavioural RAM: combinational read, whole-word write on the rising edge
  assign ram_rdata = ram_mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
    end else if (ram_enab) begin
      ram_mem[ram_addr[7:2]] <= ram_wdata;
    end
  end

  // ---------------- reference model (byte-array arithmetic) ----------------
  function automatic bit m_err(logic [31:0] a, int sz);
    return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0) || ((a / 4) >= 64);
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, int sz, bit uns);
    int nb = 1 << sz;
    int off = int'(a % 4);
    logic [31:0] v = 32'd0;
    logic [31:0] top;
    for (int i = 0; i < nb; i++) v = v + (((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
    if (nb < 4 && !uns) begin
      top = 32'd1 << (8 * nb);
      if (v >= (top >> 1)) v = v - top;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] w, logic [31:0] a, int sz, logic [31:0] d);
    logic [7:0] b [4];
    int nb = 1 << sz;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = 8'((w >> (8 * i)) & 32'hFF);
    for (int i = 0; i < nb; i++) b[off + i] = 8'((d >> (8 * i)) & 32'hFF);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request starting at a negedge; returns observed response and write activity
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit keep,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwr, output logic [31:0] waddr, output logic [31:0] wword);
    bool_busy: begin end
    rd = 32'd0; er = 1'b0; lat = -1; nwr = 0; waddr = 32'd0; wword = 32'd0;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    for (int t = 0; t < 10 && !req_ready; t++) @(negedge clk);
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    begin
      int busy_ready = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (req_ready) busy_ready++;
        if (ram_enab) begin
          nwr++; waddr = ram_addr; wword = ram_wdata;
        end
        if (resp_valid) begin
          lat = c; rd = resp_rdata; er = resp_err;
          break;
        end
      end
      chk("ready_low_busy", 32'(busy_ready), 32'd0);
    end
    if (lat < 0) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    if (keep) begin
      // hold the stale request fields away from an unintended second accept
      req_addr = 32'hFFFF_FFFC; req_size = 2'd3;
    end
    chk("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("rdata_hold", resp_rdata, rd);
  endtask

  // Run a request and compare against supplied expectations; keep model memory in step
  task automatic run(string tag, logic we, logic [1:0] sz, logic uns, logic [31:0] addr,
                     logic [31:0] wd, bit keep, logic [31:0] exp_rd, logic exp_er,
                     int exp_lat, int exp_nwr, logic [31:0] exp_waddr, logic [31:0] exp_wword);
    logic [31:0] rd, waddr, wword;
    logic er;
    int lat, nwr;
    do_req(we, sz, uns, addr, wd, keep, rd, er, lat, nwr, waddr, wword);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_er));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_wr_count"}, 32'(nwr), 32'(exp_nwr));
    if (exp_nwr == 1) begin
      chk({tag, "_wr_addr"}, waddr, exp_waddr);
      chk({tag, "_wr_word"}, wword, exp_wword);
    end
    if (we && !m_err(addr, int'(sz))) gold[addr[7:2]] = m_store(gold[addr[7:2]], addr, int'(sz), wd);
  endtask

  // Model-derived expectations for a request against the current model memory
  task automatic run_model(string tag, logic we, logic [1:0] sz, logic uns,
                           logic [31:0] addr, logic [31:0] wd, bit keep);
    bit er = m_err(addr, int'(sz));
    logic [31:0] old = er ? 32'd0 : gold[addr[7:2]];
    logic [31:0] rd = (er || we) ? 32'd0 : m_load(old, addr, int'(sz), uns);
    int lat = er ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
    int nwr = (!er && we) ? 1 : 0;
    run(tag, we, sz, uns, addr, wd, keep, rd, er, lat, nwr, addr & ~32'd3,
        er ? 32'd0 : m_store(old, addr, int'(sz), wd));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwr;
    logic [31:0] wword;
  } vec_t;

  vec_t vt [16];

  initial begin
    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFF_FF87, 1'b0, 2, 0, 32'h0};
    vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h0000_0087, 1'b0, 2, 0, 32'h0};
    vt[2]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'h0000_4321, 1'b0, 2, 0, 32'h0};
    vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h0000_BEEF, 32'h0,        1'b0, 3, 1, 32'hBEEF_4321};
    vt[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hBEEF_4321, 1'b0, 2, 0, 32'h0};
    vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h11,  32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
    vt[6]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678, 32'h0,        1'b1, 1, 0, 32'h0};
    vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFF_BEEF, 1'b0, 2, 0, 32'h0};
    vt[8]  = '{1'b0, 2'd0, 1'b1, 32'h12,  32'h0,        32'h0000_00EF, 1'b0, 2, 0, 32'h0};
    vt[9]  = '{1'b1, 2'd2, 1'b0, 32'h14,  32'h0000_80FF, 32'h0,        1'b0, 2, 1, 32'h0000_80FF};
    vt[10] = '{1'b0, 2'd1, 1'b0, 32'h14,  32'h0,        32'hFFFF_80FF, 1'b0, 2, 0, 32'h0};
    vt[11] = '{1'b0, 2'd1, 1'b1, 32'h15,  32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
    vt[12] = '{1'b0, 2'd3, 1'b0, 32'h14,  32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
    vt[13] = '{1'b1, 2'd0, 1'b0, 32'h17,  32'h0000_005A, 32'h0,        1'b0, 3, 1, 32'h5A00_80FF};
    vt[14] = '{1'b0, 2'd0, 1'b0, 32'h17,  32'h0,        32'h0000_005A, 1'b0, 2, 0, 32'h0};
    vt[15] = '{1'b0, 2'd2, 1'b0, 32'hFC,  32'h0,        32'h3F3F_3F3F, 1'b0, 2, 0, 32'h0};

    for (int i = 0; i < 64; i++) gold[i] = init_word(i);
    rst_n = 1'b0; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_ram_enab", 32'(ram_enab), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run($sformatf("vec%0d", i), vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, 1'b0,
          vt[i].rd, vt[i].er, vt[i].lat, vt[i].nwr, vt[i].addr & ~32'd3, vt[i].wword);
    end

    // SB to 0x21 abandoned by reset while merging
    begin
      int enab_seen = 0;
      int valid_seen = 0;
      req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h21;
      req_wdata = 32'h0000_00AA; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      if (ram_enab) enab_seen++;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_ram_enab", 32'(ram_enab), 32'd0);
      chk("midrst_ram_addr", ram_addr, 32'd0);
      chk("midrst_ram_wdata", ram_wdata, 32'd0);
      chk("midrst_resp_rdata", resp_rdata, 32'd0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (c == 1) rst_n = 1'b1;
        if (ram_enab) enab_seen++;
        if (resp_valid) valid_seen++;
      end
      chk("midrst_enab_count", 32'(enab_seen), 32'd0);
      chk("midrst_resp_count", 32'(valid_seen), 32'd0);
      chk("midrst_word8", ram_mem[8], gold[8]);
    end

    // Three back-to-back requests with req_valid held high
    run_model("b2b0", 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b1);
    run_model("b2b1", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1);
    run_model("b2b2", 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);

    // Randomised requests against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [31:0] a  = (32'($urandom_range(0, 69)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      run_model($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                a, $urandom, 1'b0);
    end

    begin
      int mism = 0;
      for (int i = 0; i < 64; i++) if (ram_mem[i] !== gold[i]) mism++;
      chk("ram_final_contents", 32'(mism), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end that sits directly upstream of the data RAM in the multi-cycle core. It accepts one CPU memory request at a time (byte/half/word, signed/unsigned) and drives the RAM's word address, write enable and write data. Sub-word stores use read-modify-write, because the RAM writes whole words only. It returns lane-aligned, extended load data to the datapath.

Parameters:
RAM_WORDS, 64, number of 32-bit words backed by the RAM; word indices >= RAM_WORDS are out of range

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  unit idle, request accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 byte, 1 half, 2 word, 3 reserved (treated as error)
req_unsigned  input  1  load zero-extend when 1, sign-extend when 0
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse, response complete
resp_rdata  output  32  extended load data (0 for stores/errors)
resp_err  output  1  misaligned / out-of-range / reserved size, valid with resp_valid
ram_addr  output  32  byte address to RAM, bits[1:0] always 0
ram_enab  output  1  RAM write enable
ram_wdata  output  32  RAM write word
ram_rdata  input  32  RAM combinational read word at ram_addr

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; ram_enab=0; ram_addr=0; ram_wdata=0; all latches cleared. ram_enab is decoded from state, so it drops immediately on reset.
- States: IDLE, ACCESS, MERGE, WRITE, RESP.
- IDLE: req_ready=1. On accept, latch addr, size, we, unsigned flag and wdata.
  - Error checks: half with addr[0]=1; word with addr[1:0]!=0; size=3; addr[31:2] >= RAM_WORDS.
  - Error -> RESP with err=1. No RAM access occurs.
  - Load -> ACCESS. Word store -> WRITE. Byte/half store -> MERGE.
- ACCESS: ram_addr={addr[31:2],2'b00}. Select the lane by addr[1:0] (little-endian: byte n = bits[8n+7:8n]), extend it and register it into resp_rdata. -> RESP.
- MERGE: ram_addr as above. Register ram_rdata with the target byte/half lane replaced by req_wdata[7:0]/[15:0]. -> WRITE.
- WRITE: ram_addr as above; ram_enab=1; ram_wdata=merged word (or latched wdata for word store). RAM commits on this cycle's rising edge. -> RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0. -> IDLE.
- resp_rdata and resp_err hold until the next accept.
- Latency (accept edge = cycle 0, resp_valid high in cycle N): load N=2; word store N=2; sub-word store N=3; error N=1.
- Single outstanding request; req_ready=0 in every non-IDLE state. The response channel has no backpressure.
- ram_enab is asserted only in WRITE; never in error paths.
- Reset mid-operation: the transaction is abandoned. Reset before the WRITE edge leaves RAM unchanged; no resp_valid is produced.

Decomposition:
- Package mem_access_pkg: size enum (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, byte-lane constants, functions load_extend(word, offset, size, unsigned) and store_merge(word, data, offset, size).
- Optional sub-module mem_lane_align: combinational wrapper around both functions, unit-testable in isolation. FSM and registers stay in mem_access_unit.

Test Plan:
- RAM word 4 = 0x87654321. LB addr 0x13 signed -> resp_rdata=0xFFFFFF87, err=0, resp_valid at cycle 2. LBU same -> 0x00000087. LH 0x10 -> 0x00004321.
- SH wdata=0x0000BEEF to 0x12 -> one ram_enab pulse with ram_wdata=0xBEEF4321, ram_addr=0x10; resp_valid at cycle 3; subsequent LW 0x10 -> 0xBEEF4321.
- LW 0x11 -> resp_err=1 at cycle 1, ram_enab never high, resp_rdata=0. SW 0x100 (word 64) -> resp_err=1, RAM contents unchanged.
- SB 0xAA to 0x21, rst_n pulled low during MERGE -> all outputs at reset values, ram_enab never high, word 8 unchanged, no resp_valid.
- req_valid held high with 3 back-to-back requests -> req_ready low while busy; each accepted exactly once, in order; responses match the golden model.
